// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL reset sequencer.
// All cycle counts are in refclk cycles.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        CHECK,
        RELEASE,
        RUN,
        FAULT
    } pll_state_e;

    localparam int REFCLK_HZ        = 24_000_000;
    localparam int DEF_RST_CYCLES   = 24;
    localparam int DEF_LOCK_CYCLES  = 2400;
    localparam int DEF_HB_WINDOW    = 256;
    localparam int DEF_HB_MIN_EDGES = 2;
    localparam int DEF_NUM_DOM      = 2;
    localparam int DEF_STAGGER      = 16;
    localparam int DEF_MAX_RETRY    = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hb_detect.sv
// Heartbeat detector: synchronizes the clk0-domain toggle into refclk and
// judges each fixed observation window as pass/fail.
module hb_detect #(
    parameter int HB_WINDOW    = 256,
    parameter int HB_MIN_EDGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hb_toggle,
    input  logic clear,
    output logic win_end,
    output logic pass
);

    localparam int WW = (HB_WINDOW > 1) ? $clog2(HB_WINDOW) : 1;
    localparam int EW = $clog2(HB_MIN_EDGES + 1);

    logic [2:0]    sync_q;
    logic          hb_edge;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] edge_cnt;

    assign hb_edge = sync_q[1] ^ sync_q[2];
    assign win_end = !clear && (win_cnt == WW'(HB_WINDOW - 1));
    // An edge landing in the last cycle of a window still counts for that window.
    assign pass    = (edge_cnt == EW'(HB_MIN_EDGES)) ||
                     (hb_edge && (edge_cnt == EW'(HB_MIN_EDGES - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            sync_q <= {sync_q[1:0], hb_toggle};
            if (clear || win_end) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                if (hb_edge && (edge_cnt != EW'(HB_MIN_EDGES)))
                    edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL power-up / recovery sequencer: PLL reset, lock wait, heartbeat check,
// staggered domain reset release, and run-time heartbeat monitoring.
module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
    parameter int HB_WINDOW    = DEF_HB_WINDOW,
    parameter int HB_MIN_EDGES = DEF_HB_MIN_EDGES,
    parameter int NUM_DOM      = DEF_NUM_DOM,
    parameter int STAGGER      = DEF_STAGGER,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               hb_toggle,
    input  logic               relock_req,
    output logic               pll_reset,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [7:0]         relock_cnt
);

    localparam int LAST_REL = (NUM_DOM - 1) * STAGGER;
    localparam int TMR_MAX  = max3(RST_CYCLES - 1, LOCK_CYCLES - 1, LAST_REL);
    localparam int TW       = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
    localparam int RW       = $clog2(MAX_RETRY + 1);

    pll_state_e         state_q, state_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic               fault_d, pll_reset_d, ready_d;
    logic [7:0]         relock_d, relock_inc;
    logic [NUM_DOM-1:0] dom_d;
    logic               hb_clear, win_end, hb_pass;

    assign hb_clear   = (state_q != CHECK) && (state_q != RUN);
    assign relock_inc = (relock_cnt == 8'hFF) ? 8'hFF : relock_cnt + 8'd1;

    hb_detect #(
        .HB_WINDOW   (HB_WINDOW),
        .HB_MIN_EDGES(HB_MIN_EDGES)
    ) u_hb_detect (
        .clk      (refclk),
        .rst_n    (rst_n),
        .hb_toggle(hb_toggle),
        .clear    (hb_clear),
        .win_end  (win_end),
        .pass     (hb_pass)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        fault_d  = fault;
        relock_d = relock_cnt;
        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == TW'(RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (cnt_q == TW'(LOCK_CYCLES - 1)) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (win_end) begin
                    cnt_d = '0;
                    if (hb_pass) begin
                        state_d = RELEASE;
                        retry_d = '0;
                    end else if (retry_q == RW'(MAX_RETRY - 1)) begin
                        state_d = FAULT;
                        retry_d = retry_q + 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = PLL_RST;
                        retry_d = retry_q + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (cnt_q == TW'(LAST_REL))
                    state_d = RUN;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            RUN: begin
                if (win_end && !hb_pass) begin
                    state_d  = PLL_RST;
                    cnt_d    = '0;
                    retry_d  = '0;
                    relock_d = relock_inc;
                end
            end
            FAULT: ;
            default: state_d = PLL_RST;
        endcase

        // A request overrides any same-cycle loss decision, so the count moves once.
        if (relock_req) begin
            state_d  = PLL_RST;
            cnt_d    = '0;
            retry_d  = '0;
            fault_d  = 1'b0;
            relock_d = (state_q == RUN) ? relock_inc : relock_cnt;
        end

        pll_reset_d = (state_d == PLL_RST) || (state_d == FAULT);
        ready_d     = (state_d == RUN);
        dom_d       = '0;
        if (state_d == RUN) begin
            dom_d = '1;
        end else if (state_d == RELEASE) begin
            for (int i = 0; i < NUM_DOM; i++)
                dom_d[i] = (int'(cnt_d) >= i * STAGGER);
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PLL_RST;
            cnt_q      <= '0;
            retry_q    <= '0;
            pll_reset  <= 1'b1;
            dom_rst_n  <= '0;
            ready      <= 1'b0;
            fault      <= 1'b0;
            relock_cnt <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            pll_reset  <= pll_reset_d;
            dom_rst_n  <= dom_d;
            ready      <= ready_d;
            fault      <= fault_d;
            relock_cnt <= relock_d;
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed testbench for pll_rst_seq with default timing (24/2400/256/16).
// Edge n counts refclk rising edges after rst_n release or a relock_req edge.
module tb_pll_rst_seq;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hb_toggle;
    logic       relock_req = 1'b0;
    logic       pll_reset;
    logic [1:0] dom_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] relock_cnt;

    int   tests_run = 0;
    int   tests_failed = 0;
    logic hb_en = 1'b0;
    int   hb_div = 0;

    always #5 refclk = ~refclk;

    pll_rst_seq dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .hb_toggle (hb_toggle),
        .relock_req(relock_req),
        .pll_reset (pll_reset),
        .dom_rst_n (dom_rst_n),
        .ready     (ready),
        .fault     (fault),
        .relock_cnt(relock_cnt)
    );

    // Heartbeat source: toggles every 3 refclk cycles while enabled.
    initial begin
        hb_toggle = 1'b0;
        forever begin
            @(posedge refclk);
            #2;
            if (hb_en) begin
                hb_div++;
                if (hb_div == 3) begin
                    hb_div    = 0;
                    hb_toggle = ~hb_toggle;
                end
            end
        end
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        relock_req = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        relock_req = 1'b0;
        hb_en      = 1'b0;
        repeat (2) @(posedge refclk);
        #1;
        tests_run++;
        if (pll_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_pll_reset: got %b expected 1", pll_reset); end
        tests_run++;
        if (dom_rst_n !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_dom_rst_n: got %b expected 00", dom_rst_n); end
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        tests_run++;
        if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
        tests_run++;
        if (relock_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_relock_cnt: got %0d expected 0", relock_cnt); end
    endtask

    task automatic test_power_up();
        int n = 0, pr_fall = -1, d0 = -1, d1 = -1, rdy = -1;
        hb_en = 1'b1;
        do_reset();
        while (rdy < 0 && n < 4000) begin
            tick();
            n++;
            if (pr_fall < 0 && pll_reset === 1'b0) pr_fall = n;
            if (d0 < 0 && dom_rst_n[0] === 1'b1) d0 = n;
            if (d1 < 0 && dom_rst_n[1] === 1'b1) d1 = n;
            if (rdy < 0 && ready === 1'b1) rdy = n;
        end
        tests_run++;
        if (pr_fall != 24) begin tests_failed++; $display("[TB] FAIL pwr_pll_reset_fall: got %0d expected 24", pr_fall); end
        tests_run++;
        if (d0 != 2680) begin tests_failed++; $display("[TB] FAIL pwr_dom0_release: got %0d expected 2680", d0); end
        tests_run++;
        if (d1 != 2696) begin tests_failed++; $display("[TB] FAIL pwr_dom1_release: got %0d expected 2696", d1); end
        tests_run++;
        if (rdy != 2697) begin tests_failed++; $display("[TB] FAIL pwr_ready_rise: got %0d expected 2697", rdy); end
        tests_run++;
        if (relock_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL pwr_relock_cnt: got %0d expected 0", relock_cnt); end
        tests_run++;
        if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL pwr_fault: got %b expected 0", fault); end
    endtask

    task automatic test_hb_loss();
        int n = 0, lost = -1, rdy = -1;
        logic [1:0] dom_at = 2'bxx;
        logic pr_at = 1'bx;
        hb_en = 1'b0;
        while (lost < 0 && n < 600) begin
            tick();
            n++;
            if (ready !== 1'b1) begin
                lost   = n;
                dom_at = dom_rst_n;
                pr_at  = pll_reset;
            end
        end
        tests_run++;
        if (lost < 1 || lost > 515) begin tests_failed++; $display("[TB] FAIL loss_detect_cycle: got %0d expected 1..515", lost); end
        tests_run++;
        if (dom_at !== 2'b00) begin tests_failed++; $display("[TB] FAIL loss_dom_same_cycle: got %b expected 00", dom_at); end
        tests_run++;
        if (pr_at !== 1'b1) begin tests_failed++; $display("[TB] FAIL loss_pll_reset: got %b expected 1", pr_at); end
        tests_run++;
        if (relock_cnt !== 8'd1) begin tests_failed++; $display("[TB] FAIL loss_relock_cnt: got %0d expected 1", relock_cnt); end
        hb_en = 1'b1;
        n = 0;
        while (rdy < 0 && n < 3000) begin
            tick();
            n++;
            if (ready === 1'b1) rdy = n;
        end
        tests_run++;
        if (rdy != 2697) begin tests_failed++; $display("[TB] FAIL loss_recover_ready: got %0d expected 2697", rdy); end
        tests_run++;
        if (relock_cnt !== 8'd1) begin tests_failed++; $display("[TB] FAIL loss_recover_relock_cnt: got %0d expected 1", relock_cnt); end
    endtask

    task automatic test_stuck_low();
        int n = 0, rises = 0, falls = 0;
        int rise1 = -1, rise2 = -1, fall2 = -1, fall3 = -1, flt = -1, pf = -1;
        logic prev = 1'b1;
        logic pr_at = 1'bx;
        bit saw_ready = 1'b0;
        hb_en = 1'b0;
        do_reset();
        while (flt < 0 && n < 9000) begin
            tick();
            n++;
            if (pll_reset === 1'b1 && prev === 1'b0) begin
                rises++;
                if (rises == 1) rise1 = n;
                if (rises == 2) rise2 = n;
            end
            if (pll_reset === 1'b0 && prev === 1'b1) begin
                falls++;
                if (falls == 2) fall2 = n;
                if (falls == 3) fall3 = n;
            end
            prev = pll_reset;
            if (ready === 1'b1) saw_ready = 1'b1;
            if (fault === 1'b1) begin
                flt   = n;
                pr_at = pll_reset;
            end
        end
        tests_run++;
        if (rise1 != 2680) begin tests_failed++; $display("[TB] FAIL stuck_retry1_restart: got %0d expected 2680", rise1); end
        tests_run++;
        if (fall2 != 2704) begin tests_failed++; $display("[TB] FAIL stuck_retry1_hold: got %0d expected 2704", fall2); end
        tests_run++;
        if (rise2 != 5360) begin tests_failed++; $display("[TB] FAIL stuck_retry2_restart: got %0d expected 5360", rise2); end
        tests_run++;
        if (fall3 != 5384) begin tests_failed++; $display("[TB] FAIL stuck_retry2_hold: got %0d expected 5384", fall3); end
        tests_run++;
        if (flt != 8040) begin tests_failed++; $display("[TB] FAIL stuck_fault_cycle: got %0d expected 8040", flt); end
        tests_run++;
        if (pr_at !== 1'b1) begin tests_failed++; $display("[TB] FAIL stuck_fault_pll_reset: got %b expected 1", pr_at); end
        tests_run++;
        if (saw_ready != 1'b0) begin tests_failed++; $display("[TB] FAIL stuck_ready_seen: got %b expected 0", saw_ready); end
        repeat (100) tick();
        tests_run++;
        if (fault !== 1'b1 || pll_reset !== 1'b1 || dom_rst_n !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL stuck_fault_hold: got fault=%b pll_reset=%b dom=%b expected 1 1 00", fault, pll_reset, dom_rst_n);
        end
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        tests_run++;
        if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL stuck_relock_fault_clear: got %b expected 0", fault); end
        tests_run++;
        if (pll_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL stuck_relock_pll_reset: got %b expected 1", pll_reset); end
        tests_run++;
        if (relock_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL stuck_relock_cnt: got %0d expected 0", relock_cnt); end
        hb_en = 1'b1;
        n = 0;
        while (pf < 0 && n < 100) begin
            tick();
            n++;
            if (pll_reset === 1'b0) pf = n;
        end
        tests_run++;
        if (pf != 24) begin tests_failed++; $display("[TB] FAIL stuck_restart_pll_reset_fall: got %0d expected 24", pf); end
    endtask

    task automatic test_relock_wait_lock();
        int n = 0, pr_fall = -1, d0 = -1, rdy = -1;
        hb_en = 1'b1;
        do_reset();
        repeat (100) tick();
        tests_run++;
        if (pll_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL wl_in_wait_lock: got pll_reset=%b expected 0", pll_reset); end
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        tests_run++;
        if (pll_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL wl_relock_pll_reset: got %b expected 1", pll_reset); end
        tests_run++;
        if (relock_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL wl_relock_cnt: got %0d expected 0", relock_cnt); end
        while (rdy < 0 && n < 3000) begin
            tick();
            n++;
            if (pr_fall < 0 && pll_reset === 1'b0) pr_fall = n;
            if (d0 < 0 && dom_rst_n[0] === 1'b1) d0 = n;
            if (rdy < 0 && ready === 1'b1) rdy = n;
        end
        tests_run++;
        if (pr_fall != 24) begin tests_failed++; $display("[TB] FAIL wl_pll_reset_fall: got %0d expected 24", pr_fall); end
        tests_run++;
        if (d0 != 2680) begin tests_failed++; $display("[TB] FAIL wl_dom0_release: got %0d expected 2680", d0); end
        tests_run++;
        if (rdy != 2697) begin tests_failed++; $display("[TB] FAIL wl_ready_rise: got %0d expected 2697", rdy); end
    endtask

    task automatic test_relock_loss_same_cycle();
        int n = 0, d0 = -1;
        hb_en = 1'b1;
        do_reset();
        while (d0 < 0 && n < 3000) begin
            tick();
            n++;
            if (dom_rst_n[0] === 1'b1) d0 = n;
        end
        hb_en = 1'b0;
        while (ready !== 1'b1 && n < 3100) begin
            tick();
            n++;
        end
        tests_run++;
        if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL same_reach_run: got ready=%b expected 1", ready); end
        repeat (255) tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        tests_run++;
        if (relock_cnt !== 8'd1) begin tests_failed++; $display("[TB] FAIL same_relock_cnt: got %0d expected 1", relock_cnt); end
        tests_run++;
        if (ready !== 1'b0 || dom_rst_n !== 2'b00 || pll_reset !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL same_outputs: got ready=%b dom=%b pll_reset=%b expected 0 00 1", ready, dom_rst_n, pll_reset);
        end
        repeat (50) tick();
        tests_run++;
        if (relock_cnt !== 8'd1) begin tests_failed++; $display("[TB] FAIL same_relock_cnt_later: got %0d expected 1", relock_cnt); end
    endtask

    task automatic test_async_reset();
        int n = 0, d0 = -1;
        hb_en = 1'b1;
        do_reset();
        while (d0 < 0 && n < 3000) begin
            tick();
            n++;
            if (dom_rst_n[0] === 1'b1) d0 = n;
        end
        repeat (3) tick();
        tests_run++;
        if (dom_rst_n !== 2'b01) begin tests_failed++; $display("[TB] FAIL async_mid_release: got dom=%b expected 01", dom_rst_n); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (pll_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL async_pll_reset: got %b expected 1", pll_reset); end
        tests_run++;
        if (dom_rst_n !== 2'b00) begin tests_failed++; $display("[TB] FAIL async_dom_rst_n: got %b expected 00", dom_rst_n); end
        tests_run++;
        if (ready !== 1'b0 || fault !== 1'b0 || relock_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_status: got ready=%b fault=%b relock_cnt=%0d expected 0 0 0", ready, fault, relock_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_hb_loss();
        test_stuck_low();
        test_relock_wait_lock();
        test_relock_loss_same_cycle();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
